mpuc_cmul_cfg: RTL and testbench
================================

MPUC_CMUL_CFG -- requirements
Module: mpuc_cmul_cfg

Interface
REQ-001 SHALL have parameter NB, default 12: signed data width of DR, DI, DOR, DOI.
REQ-002 SHALL have parameter NC, default 16: coefficient width, format Q2.(NC-2).
REQ-003 SHALL have parameter RND, default 1: 1 selects round-half-up, 0 selects truncation (floor).
REQ-004 SHALL use one clock and a synchronous active-high reset: CLK, input, 1 bit, rising-edge clock; RST, input, 1 bit, synchronous active-high reset.
REQ-005 Port EI, input, 1 bit: clock enable; all state advances only when EI=1.
REQ-006 Port ED, input, 1 bit: input sample strobe, qualified by EI.
REQ-007 Port MODE, input, 2 bits: constant select, sampled with the input sample.
REQ-008 Port MPYJ, input, 1 bit: multiply the result by -j, sampled with the input sample.
REQ-009 Port DR / DI, inputs, NB bits signed each: real / imaginary input.
REQ-010 Port DOR / DOI, outputs, NB bits signed each: real / imaginary result.
REQ-011 Port DV, output, 1 bit: DOR/DOI hold a new result.
REQ-012 Port OVF, output, 1 bit: sticky saturation flag.
REQ-013 Port COLL, output, 1 bit: sticky input-collision flag.

Function
REQ-014 SHALL accept a sample on a clock edge with EI=1, ED=1, and no collision; DR, DI, MODE and MPYJ are captured together.
REQ-015 SHALL map MODE to coefficient K = round(c*2^(NC-2)), with c = 0: 0.707107, 1: 0.541196, 2: 1.306563, 3: 0.923880. For NC=16, K = 11585, 8867, 21407, 15137.
REQ-016 SHALL use one shared NB x NC signed multiplier, time-multiplexed:
- real part on the first EI cycle after accept;
- imaginary part on the second EI cycle after accept.
REQ-017 SHALL form each product at full width NB+NC, with no intermediate truncation.
REQ-018 SHALL scale each product as follows:
- RND=1: y = (p + 2^(NC-3)) >>> (NC-2);
- RND=0: y = p >>> (NC-2).
REQ-019 SHALL saturate y to [-2^(NB-1), 2^(NB-1)-1].
REQ-020 SHALL output (DOR, DOI) = (yr, yi) when the captured MPYJ=0.
REQ-021 SHALL output (DOR, DOI) = (yi, -yr) when the captured MPYJ=1; -(-2^(NB-1)) saturates to 2^(NB-1)-1.
REQ-022 SHALL present the result with DV=1 on the 4th EI-qualified edge after the accept edge (latency 4 EI cycles).
REQ-023 SHALL drive DV=0 on every other EI-qualified edge.
REQ-024 SHALL hold DOR and DOI between results.
REQ-025 SHALL freeze all registers, including DV, DOR, DOI and the flags, while EI=0, so latency stretches by the number of stalled clocks.
REQ-026 SHALL treat ED=1 on the EI cycle immediately following an accept as a collision:
- that sample is discarded;
- COLL is set;
- the in-flight sample completes unaffected.
REQ-027 SHALL allow back-to-back accepts every 2nd EI cycle, giving a throughput of one complex sample per 2 EI cycles.
REQ-028 SHALL set OVF when saturation occurs on either component, including the MPYJ negation case.
REQ-029 SHALL clear OVF and COLL only by reset.
REQ-030 SHALL apply MODE and MPYJ per sample; changing them between accepts SHALL NOT affect in-flight samples.

Reset
REQ-031 RST=1 SHALL take effect on the clock edge regardless of EI, and SHALL take priority over ED.
REQ-032 On reset:
- DOR=0, DOI=0, DV=0, OVF=0, COLL=0;
- all pipeline registers, the valid bits and the phase state are cleared.
REQ-033 A sample in flight when reset occurs SHALL be discarded and SHALL never produce DV.
REQ-034 The first EI cycle after RST deasserts SHALL accept ED normally.

Verification
REQ-035 NB=12, NC=16, RND=1, MODE=0, MPYJ=0, DR=1000, DI=-1000 -> DV=1 on the 4th EI edge, DOR=707, DOI=-707, OVF=0.
REQ-036 MODE=1, MPYJ=1, DR=1000, DI=0 -> DOR=0, DOI=-541.
REQ-037 MODE=2, DR=2047, DI=-2048 -> DOR=2047, DOI=-2048, OVF=1 and stays 1 through later in-range samples until RST.
REQ-038 ED on consecutive EI cycles (samples A, B), then a third sample C two EI cycles later -> only A and C produce DV, COLL=1, A's result correct.
REQ-039 EI held low 3 clocks between accept and output -> DV appears 7 clocks after the accept edge, values identical to the unstalled case.
REQ-040 RST pulsed 2 EI cycles after an accept -> no DV for that sample, all outputs 0, a new sample accepted on the next cycle with normal latency.

Source files
------------

// File: rtl/mpuc_cmul_cfg_if.sv
// Sample/result bundle for mpuc_cmul_cfg: the sample strobe and operands go in,
// the scaled complex result and its status flags come out.
interface mpuc_cmul_cfg_if #(
  parameter int NB = 12
);
  logic                 EI;
  logic                 ED;
  logic [1:0]           MODE;
  logic                 MPYJ;
  logic signed [NB-1:0] DR;
  logic signed [NB-1:0] DI;
  logic signed [NB-1:0] DOR;
  logic signed [NB-1:0] DOI;
  logic                 DV;
  logic                 OVF;
  logic                 COLL;

  modport master (
    output EI, ED, MODE, MPYJ, DR, DI,
    input  DOR, DOI, DV, OVF, COLL
  );

  modport slave (
    input  EI, ED, MODE, MPYJ, DR, DI,
    output DOR, DOI, DV, OVF, COLL
  );
endinterface

// File: rtl/mpuc_cmul_cfg.sv
// Complex-by-constant multiplier: one shared NB x NC multiplier handles the real
// and imaginary parts on successive enabled cycles, then scales, saturates and
// optionally rotates by -j. Accepts one sample per two enabled cycles.
module mpuc_cmul_cfg #(
  parameter int NB  = 12,
  parameter int NC  = 16,
  parameter int RND = 1
) (
  input  logic            CLK,
  input  logic            RST,
  mpuc_cmul_cfg_if.slave  bus
);
  localparam int PW = NB + NC;

  localparam int K0 = int'(0.707107 * real'(2 ** (NC - 2)));
  localparam int K1 = int'(0.541196 * real'(2 ** (NC - 2)));
  localparam int K2 = int'(1.306563 * real'(2 ** (NC - 2)));
  localparam int K3 = int'(0.923880 * real'(2 ** (NC - 2)));

  localparam logic signed [NB-1:0] YMAX = {1'b0, {(NB-1){1'b1}}};
  localparam logic signed [NB-1:0] YMIN = {1'b1, {(NB-1){1'b0}}};
  localparam logic signed [PW-1:0] WMAX = PW'(YMAX);
  localparam logic signed [PW-1:0] WMIN = PW'(YMIN);
  localparam logic signed [PW-1:0] BIAS = (RND != 0) ? (PW'(1) << (NC - 3)) : '0;

  // r_v[n] marks a sample that was accepted n+1 enabled cycles ago.
  logic [3:0]           r_v;
  logic [3:0]           r_j;
  logic signed [NB-1:0] r_xr, r_xi;
  logic signed [NC-1:0] r_k;
  logic signed [PW-1:0] r_p;
  logic signed [NB-1:0] r_yr, r_yi;
  logic                 r_or, r_oi;
  logic signed [NB-1:0] r_dor, r_doi;
  logic                 r_dv, r_ovf, r_coll;

  logic                 w_acc, w_col;
  logic signed [NC-1:0] w_k;
  logic signed [NB-1:0] w_opa;
  logic signed [PW-1:0] w_p, w_pr, w_sh;
  logic signed [NB-1:0] w_y, w_ng;
  logic                 w_sat, w_nsat;

  // A strobe on the cycle right after an accept would collide with the imaginary-part multiply.
  assign w_acc = bus.ED && !r_v[0];
  assign w_col = bus.ED &&  r_v[0];

  always_comb begin
    w_k = NC'(K0);
    case (bus.MODE)
      2'd0: w_k = NC'(K0);
      2'd1: w_k = NC'(K1);
      2'd2: w_k = NC'(K2);
      2'd3: w_k = NC'(K3);
      default: w_k = NC'(K0);
    endcase
  end

  assign w_opa = r_v[0] ? r_xr : r_xi;
  assign w_p   = PW'(w_opa) * PW'(r_k);
  assign w_pr  = r_p + BIAS;
  assign w_sh  = w_pr >>> (NC - 2);

  // NOTE: every variable written here gets a default first, so no path infers a latch.
  always_comb begin
    w_y   = w_sh[NB-1:0];
    w_sat = 1'b0;
    if (w_sh > WMAX) begin
      w_y   = YMAX;
      w_sat = 1'b1;
    end else if (w_sh < WMIN) begin
      w_y   = YMIN;
      w_sat = 1'b1;
    end
  end

  always_comb begin
    w_ng   = -r_yr;
    w_nsat = 1'b0;
    if (r_yr == YMIN) begin
      w_ng   = YMAX;
      w_nsat = 1'b1;
    end
  end

  // NOTE: state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_v    <= '0;
      r_j    <= '0;
      r_xr   <= '0;
      r_xi   <= '0;
      r_k    <= '0;
      r_p    <= '0;
      r_yr   <= '0;
      r_yi   <= '0;
      r_or   <= 1'b0;
      r_oi   <= 1'b0;
      r_dor  <= '0;
      r_doi  <= '0;
      r_dv   <= 1'b0;
      r_ovf  <= 1'b0;
      r_coll <= 1'b0;
    end else if (bus.EI) begin
      r_v <= {r_v[2:0], w_acc};
      r_j <= {r_j[2:0], bus.MPYJ};
      if (w_acc) begin
        r_xr <= bus.DR;
        r_xi <= bus.DI;
        r_k  <= w_k;
      end
      if (r_v[0] || r_v[1]) r_p <= w_p;
      if (r_v[1]) begin
        r_yr <= w_y;
        r_or <= w_sat;
      end
      if (r_v[2]) begin
        r_yi <= w_y;
        r_oi <= w_sat;
      end
      r_dv <= r_v[3];
      if (r_v[3]) begin
        if (r_j[3]) begin
          r_dor <= r_yi;
          r_doi <= w_ng;
          r_ovf <= r_ovf | r_or | r_oi | w_nsat;
        end else begin
          r_dor <= r_yr;
          r_doi <= r_yi;
          r_ovf <= r_ovf | r_or | r_oi;
        end
      end
      if (w_col) r_coll <= 1'b1;
    end
  end

  assign bus.DOR  = r_dor;
  assign bus.DOI  = r_doi;
  assign bus.DV   = r_dv;
  assign bus.OVF  = r_ovf;
  assign bus.COLL = r_coll;
endmodule

// File: tb/tb_mpuc_cmul_cfg.sv
// Bench for mpuc_cmul_cfg: expected results are queued at accept time and compared
// when DV appears, with latency counted in enabled cycles.
module tb_mpuc_cmul_cfg;
  localparam int NB = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mpuc_cmul_cfg_if #(.NB(NB)) bus();

  mpuc_cmul_cfg #(.NB(NB), .NC(16), .RND(1)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  typedef struct {
    int er;
    int ei;
    bit ov;
    int due;
    int acc_clk;
  } exp_t;

  typedef struct {
    bit [1:0] mode;
    bit       j;
    int       dr;
    int       di;
    int       er;
    int       ei;
    bit       ov;
  } vec_t;

  exp_t q[$];
  vec_t vecs[7];
  int   kt[4] = '{11585, 8867, 21407, 15137};

  int checks = 0;
  int fails  = 0;
  int ei_cnt = 0;
  int clk_cnt = 0;
  int last_lat = -1;
  bit last_acc = 1'b0;
  bit exp_ovf  = 1'b0;
  bit exp_coll = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ysat(input int x, input int k, output bit o);
    real v;
    v = $floor((real'(x) * real'(k)) / 16384.0 + 0.5);
    o = 1'b0;
    if (v > 2047.0) begin
      o = 1'b1;
      return 2047;
    end
    if (v < -2048.0) begin
      o = 1'b1;
      return -2048;
    end
    return int'(v);
  endfunction

  function automatic void model(input bit [1:0] m, input bit j, input int dr, input int di,
                                output int er, output int eim, output bit ov);
    int yr, yi;
    bit o1, o2;
    yr = ysat(dr, kt[m], o1);
    yi = ysat(di, kt[m], o2);
    ov = o1 | o2;
    if (j) begin
      er  = yi;
      eim = -yr;
      if (eim > 2047) begin
        eim = 2047;
        ov  = 1'b1;
      end
    end else begin
      er  = yr;
      eim = yi;
    end
  endfunction

  task automatic drive(input bit r, input bit e, input bit d, input bit [1:0] m, input bit j,
                       input int dr, input int di, input int er, input int eim, input bit ov);
    exp_t x;
    @(negedge clk);
    rst      = r;
    bus.EI   = e;
    bus.ED   = d;
    bus.MODE = m;
    bus.MPYJ = j;
    bus.DR   = NB'(dr);
    bus.DI   = NB'(di);
    @(posedge clk);
    clk_cnt++;
    if (r) begin
      q.delete();
      last_acc = 1'b0;
      exp_ovf  = 1'b0;
      exp_coll = 1'b0;
    end else if (e) begin
      ei_cnt++;
      if (d && !last_acc) begin
        x.er = er; x.ei = eim; x.ov = ov; x.due = ei_cnt + 4; x.acc_clk = clk_cnt;
        q.push_back(x);
      end
      if (d && last_acc) exp_coll = 1'b1;
      last_acc = d && !last_acc;
    end
    #1;
    if (!r && e) begin
      if (bus.DV) begin
        if (q.size() == 0) begin
          check("dv_unexpected", 1, 0);
        end else begin
          x = q.pop_front();
          exp_ovf |= x.ov;
          check("latency_ei", ei_cnt, x.due);
          check("dor", int'(bus.DOR), x.er);
          check("doi", int'(bus.DOI), x.ei);
          check("ovf", int'(bus.OVF), int'(exp_ovf));
          check("coll", int'(bus.COLL), int'(exp_coll));
          last_lat = clk_cnt - x.acc_clk;
        end
      end else if (q.size() != 0 && q[0].due <= ei_cnt) begin
        check("dv_missing", 0, 1);
        void'(q.pop_front());
      end
    end
  endtask

  task automatic idle(input bit e);
    drive(1'b0, e, 1'b0, 2'd0, 1'b0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic send(input bit e, input bit d, input bit [1:0] m, input bit j,
                      input int dr, input int di);
    int er, eim;
    bit ov;
    model(m, j, dr, di, er, eim, ov);
    drive(1'b0, e, d, m, j, dr, di, er, eim, ov);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 0, 0, 0, 0, 1'b0);
    check("rst_dor", int'(bus.DOR), 0);
    check("rst_doi", int'(bus.DOI), 0);
    check("rst_dv", int'(bus.DV), 0);
    check("rst_ovf", int'(bus.OVF), 0);
    check("rst_coll", int'(bus.COLL), 0);
  endtask

  initial begin
    rst = 1'b1; bus.EI = 1'b0; bus.ED = 1'b0; bus.MODE = '0; bus.MPYJ = 1'b0;
    bus.DR = '0; bus.DI = '0;

    vecs[0] = '{2'd0, 1'b0,  1000, -1000,  707,  -707, 1'b0};
    vecs[1] = '{2'd1, 1'b1,  1000,     0,    0,  -541, 1'b0};
    vecs[2] = '{2'd3, 1'b0,     0,     0,    0,     0, 1'b0};
    vecs[3] = '{2'd3, 1'b1, -1000,   500,  462,   924, 1'b0};
    vecs[4] = '{2'd0, 1'b0, -2048, -2048, -1448, -1448, 1'b0};
    vecs[5] = '{2'd2, 1'b0,  2047, -2048, 2047, -2048, 1'b1};
    vecs[6] = '{2'd1, 1'b0,   100,   100,   54,    54, 1'b0};

    do_reset();
    do_reset();

    // Table vectors, back to back at the maximum rate.
    foreach (vecs[i]) begin
      drive(1'b0, 1'b1, 1'b1, vecs[i].mode, vecs[i].j, vecs[i].dr, vecs[i].di,
            vecs[i].er, vecs[i].ei, vecs[i].ov);
      idle(1'b1);
    end
    repeat (4) idle(1'b1);
    check("ovf_sticky", int'(bus.OVF), 1);
    check("coll_clear", int'(bus.COLL), 0);

    // Collision: A accepted, B on the next cycle dropped, C accepted later.
    send(1'b1, 1'b1, 2'd0, 1'b0, 1000, -1000);
    send(1'b1, 1'b1, 2'd2, 1'b1, -500, 300);
    idle(1'b1);
    send(1'b1, 1'b1, 2'd1, 1'b0, -700, 900);
    repeat (6) idle(1'b1);
    check("coll_set", int'(bus.COLL), 1);

    // Stall of three clocks between accept and result.
    send(1'b1, 1'b1, 2'd0, 1'b0, 1000, -1000);
    idle(1'b1);
    repeat (3) idle(1'b0);
    repeat (3) idle(1'b1);
    check("stall_latency_clk", last_lat, 7);
    idle(1'b0);
    check("stall_dv_frozen", int'(bus.DV), 1);
    check("stall_dor_frozen", int'(bus.DOR), 707);
    idle(1'b1);
    check("dv_drop", int'(bus.DV), 0);
    check("dor_hold", int'(bus.DOR), 707);

    // Reset two enabled cycles after an accept discards that sample.
    send(1'b1, 1'b1, 2'd1, 1'b1, 1000, 0);
    idle(1'b1);
    do_reset();
    send(1'b1, 1'b1, 2'd0, 1'b0, 1000, -1000);
    repeat (5) idle(1'b1);
    check("post_rst_dor", int'(bus.DOR), 707);

    // -j rotation of a saturated negative real part.
    send(1'b1, 1'b1, 2'd2, 1'b1, -1568, 0);
    repeat (5) idle(1'b1);
    check("neg_sat_doi", int'(bus.DOI), 2047);
    check("neg_sat_ovf", int'(bus.OVF), 1);

    // Random traffic with stalls and collisions.
    do_reset();
    for (int n = 0; n < 80; n++) begin
      send($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 4095)) - 2048,
           int'($urandom_range(0, 4095)) - 2048);
    end
    repeat (10) idle(1'b1);
    check("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
